// File: rtl/bcd_conv8.sv
// Sequential double-dabble binary-to-BCD converter for the 8-digit display word, one bit per clock.
// Busy for BIN_W+1 cycles after an accepted start, then done pulses for one cycle; start is ignored while busy.
module bcd_conv8 #(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [31:0]      bcd_out,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BIN_W-1:0] r_bin;
  logic [31:0]      r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [31:0]      w_adj;
  logic [31:0]      w_bcd_nxt;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(1));

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 8; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    w_bcd_nxt = {w_adj[30:0], r_bin[BIN_W-1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Display outputs change only on the final iteration, never mid-conversion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else if (w_accept) begin
      r_bin <= bin_in;
      r_bcd <= '0;
      r_cnt <= CW'(BIN_W);
      r_ovf <= (32'(bin_in) > 32'd99_999_999);
    end else if (r_state == S_SHIFT) begin
      r_bcd <= w_bcd_nxt;
      r_bin <= {r_bin[BIN_W-2:0], 1'b0};
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_last) begin
        bcd_out  <= r_ovf ? 32'h9999_9999 : w_bcd_nxt;
        overflow <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv8.sv
// Randomized self-checking bench for bcd_conv8 against a decimal-arithmetic reference model.
// Outputs are sampled on the falling edge; the k-th falling edge after the accepting edge N shows the value seen at edge N+k.
module tb_bcd_conv8;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [26:0] bin_in;
  logic [31:0] bcd_out;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_conv8 #(.BIN_W(27)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Convert v; optionally pulse start again at the k-th cycle (0 = never).
  task automatic run_conv(input int unsigned v, input int again_k);
    logic [31:0] prev_bcd;
    logic        prev_ovf;
    logic [31:0] exp_bcd;
    logic        exp_ovf;
    exp_bcd = ref_bcd(v);
    exp_ovf = (v > 32'd99_999_999);
    @(negedge clk);
    prev_bcd = bcd_out;
    prev_ovf = overflow;
    start    = 1'b1;
    bin_in   = 27'(v);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k < 28) begin
        chk("hold_bcd", bcd_out, prev_bcd);
        chk("hold_ovf", 32'(overflow), 32'(prev_ovf));
        chk("busy_shift", 32'(busy), 32'd1);
        chk("done_low", 32'(done), 32'd0);
      end else if (k == 28) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd1);
        chk("bcd_value", bcd_out, exp_bcd);
        chk("ovf_value", 32'(overflow), 32'(exp_ovf));
      end else begin
        chk("done_after", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
      end
      start  = (k == again_k);
      bin_in = 27'($urandom);
    end
  endtask

  initial begin
    int unsigned rv;
    int          dt[$];
    logic        prev_done;

    reset_n = 1'b0;
    start   = 1'b0;
    bin_in  = '0;
    #3;
    chk("rst_bcd", bcd_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_conv(0, 0);
    run_conv(12_345_678, 0);
    run_conv(99_999_999, 0);
    run_conv(100_000_000, 0);
    run_conv(134_217_727, 0);
    run_conv(42, 5);
    run_conv(5, 0);
    for (int i = 0; i < 6; i++) begin
      rv = $urandom_range(99_999_999, 0);
      run_conv(rv, 0);
      rv = $urandom_range(134_217_727, 0);
      run_conv(rv, 0);
    end

    // Reset in the middle of a conversion.
    run_conv(87_654_321, 0);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 27'd12_345_678;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bcd", bcd_out, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(done), 32'd0);
    end
    run_conv(7, 0);

    // Start held high: conversions repeat with one idle cycle between them.
    @(negedge clk);
    start     = 1'b1;
    bin_in    = 27'd555;
    prev_done = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      chk("held_busy_gap", 32'(busy), 32'(!prev_done));
      if (done) begin
        dt.push_back(t);
        chk("held_bcd", bcd_out, ref_bcd(555));
      end
      prev_done = done;
    end
    start = 1'b0;
    chk("held_done_count", 32'(dt.size()), 32'd3);
    if (dt.size() > 0) chk("held_first_done", 32'(dt[0]), 32'd28);
    for (int i = 1; i < dt.size(); i++) begin
      chk("held_spacing", 32'(dt[i] - dt[i-1]), 32'd29);
    end
    repeat (35) @(negedge clk);
    chk("held_drain_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_conv8.md
BCD_CONV8 -- requirements
Module: bcd_conv8

Interface
REQ-001 The module SHALL have parameter BIN_W, default 27, giving the binary input width; legal range 4..27.
REQ-002 The module SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port start, input, 1, conversion request; sampled high on a rising clk edge.
REQ-005 The module SHALL have port bin_in, input, BIN_W, unsigned binary value; sampled only on an accepted start.
REQ-006 The module SHALL have port bcd_out, output, 32, eight packed BCD digits.
  - Digit 7 (most significant) is in bits [31:28]; digit 0 is in bits [3:0].
  - The 32-bit format is the display data word for the 8-digit display path.
REQ-007 The module SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 The module SHALL have port done, output, 1, one-cycle pulse when bcd_out has been updated.
REQ-009 The module SHALL have port overflow, output, 1, high when the last accepted value exceeded 99,999,999.

Function
REQ-010 The module SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 In IDLE, start=1 SHALL cause the following on the same edge:
  - latch bin_in into a shift register;
  - clear the 32-bit BCD scratch register;
  - load the bit counter with BIN_W;
  - enter SHIFT.
REQ-012 In SHIFT, each cycle SHALL perform one double-dabble iteration:
  - add 3 to every scratch nibble that is >=5;
  - shift {scratch, binary} left by one bit;
  - decrement the bit counter.
REQ-013 After the BIN_W-th iteration the FSM SHALL enter DONE.
REQ-014 In DONE, the FSM SHALL assert done for exactly one cycle and then return to IDLE.
REQ-015 Latency SHALL be fixed: with start accepted at edge N, busy=1 for edges N+1..N+BIN_W and done=1 after edge N+BIN_W+1 (28 cycles for BIN_W=27).
REQ-016 bcd_out and overflow SHALL update only on the edge that enters DONE; they hold their previous values during SHIFT, so the display never shows intermediate values.
REQ-017 If the latched value is greater than 99,999,999, bcd_out SHALL be loaded with 32'h9999_9999 and overflow with 1; otherwise overflow SHALL be 0.
REQ-018 start asserted during SHIFT SHALL be ignored; it is not queued.
REQ-019 start asserted during the DONE cycle SHALL be ignored; the first acceptable start is the cycle after done.
REQ-020 busy SHALL be 1 exactly in SHIFT and DONE; done SHALL be 1 only in DONE.
REQ-021 A start held high continuously SHALL cause back-to-back conversions, one every BIN_W+2 cycles.
REQ-022 The bit counter SHALL be wide enough for BIN_W and SHALL NOT wrap below zero.

Reset
REQ-023 reset_n=0 SHALL asynchronously force state=IDLE, bcd_out=0, busy=0, done=0, overflow=0, and clear the scratch and shift registers.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the next start after reset release SHALL convert normally.

Verification
REQ-025 start with bin_in=0 -> after 28 cycles done=1, bcd_out=32'h0000_0000, overflow=0.
REQ-026 start with bin_in=12,345,678 -> done at edge N+28, bcd_out=32'h1234_5678; bcd_out unchanged from its previous value during edges N+1..N+27.
REQ-027 bin_in=99,999,999 -> bcd_out=32'h9999_9999, overflow=0; bin_in=100,000,000 -> bcd_out=32'h9999_9999, overflow=1.
REQ-028 start pulsed again at edge N+5 during a conversion of 42 -> single done at N+28, bcd_out=32'h0000_0042, no second conversion.
REQ-029 reset_n low at edge N+10 during a conversion -> all outputs 0 immediately, no done; then start with 7 -> bcd_out=32'h0000_0007.
REQ-030 start held high for 100 cycles -> done pulses spaced exactly 29 cycles apart, busy low only on the cycle between conversions.
